draw_scheduler: RTL and testbench

Frame sequencer for the tile renderer. It owns the NUM_LINES erase engines and NUM_LINES draw engines and runs them one at a time: first erase lines 0..N-1, then draw lines 0..N-1. It muxes the active engine's pixel stream onto the single VGA write port and pulses frame-complete back to the game FSM.

---
 rtl/draw_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Frame sequencer: runs NUM_LINES erase engines then NUM_LINES draw engines one at a time and muxes the active pixel stream to VGA.
// Define DRAW_SCHED_TIMEOUT_EN to add a per-engine watchdog that raises a sticky sched_error.
module draw_scheduler #(
   parameter int NUM_LINES      = 6,
   parameter int X_W            = 9,
   parameter int Y_W            = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     draw_go,
   input  logic [NUM_LINES-1:0]     draw_done,
   input  logic [NUM_LINES-1:0]     erase_done,
   input  logic [NUM_LINES-1:0]     draw_colour,
   input  logic [NUM_LINES-1:0]     erase_colour,
   input  logic [NUM_LINES*X_W-1:0] draw_x,
   input  logic [NUM_LINES*Y_W-1:0] draw_y,
   input  logic [NUM_LINES*X_W-1:0] erase_x,
   input  logic [NUM_LINES*Y_W-1:0] erase_y,
   output logic [NUM_LINES-1:0]     draw_enable,
   output logic [NUM_LINES-1:0]     erase_enable,
   output logic                     vga_enable,
   output logic [X_W-1:0]           x_out,
   output logic [Y_W-1:0]           y_out,
   output logic [2:0]               colour_out,
   output logic                     all_drawing_done,
   output logic                     busy,
   output logic                     sched_error
);
   localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_ERASE_GAP, S_DRAW, S_DRAW_GAP, S_FINISH
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 pending_q, pending_d;
   logic [NUM_LINES-1:0] erase_en_q, erase_en_d;
   logic [NUM_LINES-1:0] draw_en_q, draw_en_d;
   logic                 vga_q, vga_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic [2:0]           colour_q, colour_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 running, sel_done, run_timeout;
   logic                 pix_erase, pix_draw;

   assign running  = (state_q == S_ERASE) || (state_q == S_DRAW);
   assign sel_done = (state_q == S_ERASE) ? erase_done[idx_q] : draw_done[idx_q];

`ifdef DRAW_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             sched_error_q, sched_error_d;

   // Counter restarts on every gap/idle cycle, so each engine gets a fresh budget.
   always_comb begin
      wd_cnt_d      = running ? wd_cnt_q + CNT_W'(1) : '0;
      run_timeout   = running && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      sched_error_d = sched_error_q | (run_timeout & ~sel_done);
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         wd_cnt_q      <= '0;
         sched_error_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         sched_error_q <= sched_error_d;
      end
   end

   assign sched_error = sched_error_q;
`else
   assign run_timeout = 1'b0;
   // No watchdog: the flag can never be raised.
   assign sched_error = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      case (state_q)
         S_IDLE: begin
            if (draw_go || pending_q) begin
               state_d = S_ERASE;
               idx_d   = '0;
            end
         end
         S_ERASE: if (sel_done || run_timeout) state_d = S_ERASE_GAP;
         S_ERASE_GAP: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_DRAW;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_ERASE;
            end
         end
         S_DRAW: if (sel_done || run_timeout) state_d = S_DRAW_GAP;
         S_DRAW_GAP: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_DRAW;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      // Idle either launches the queued frame or has nothing queued; only one frame is held.
      if (state_q == S_IDLE) pending_d = 1'b0;
      else if (draw_go)      pending_d = 1'b1;

      erase_en_d = (state_d == S_ERASE) ? (NUM_LINES'(1) << idx_d) : '0;
      draw_en_d  = (state_d == S_DRAW)  ? (NUM_LINES'(1) << idx_d) : '0;
      done_d     = (state_d == S_FINISH);
      busy_d     = (state_d != S_IDLE);

      pix_erase = erase_en_q[idx_q] & ~erase_done[idx_q];
      pix_draw  = draw_en_q[idx_q]  & ~draw_done[idx_q];
      vga_d     = pix_erase | pix_draw;
      x_d       = x_q;
      y_d       = y_q;
      colour_d  = colour_q;
      if (pix_erase) begin
         x_d      = erase_x[idx_q*X_W +: X_W];
         y_d      = erase_y[idx_q*Y_W +: Y_W];
         colour_d = {3{erase_colour[idx_q]}};
      end else if (pix_draw) begin
         x_d      = draw_x[idx_q*X_W +: X_W];
         y_d      = draw_y[idx_q*Y_W +: Y_W];
         colour_d = {3{draw_colour[idx_q]}};
      end
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         pending_q  <= 1'b0;
         erase_en_q <= '0;
         draw_en_q  <= '0;
         vga_q      <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         colour_q   <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         erase_en_q <= erase_en_d;
         draw_en_q  <= draw_en_d;
         vga_q      <= vga_d;
         x_q        <= x_d;
         y_q        <= y_d;
         colour_q   <= colour_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign erase_enable     = erase_en_q;
   assign draw_enable      = draw_en_q;
   assign vga_enable       = vga_q;
   assign x_out            = x_q;
   assign y_out            = y_q;
   assign colour_out       = colour_q;
   assign all_drawing_done = done_q;
   assign busy             = busy_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: behavioural engines plus a timeline model of each frame (engine start/length arithmetic).
// Build with DRAW_SCHED_TIMEOUT_EN to exercise the watchdog with a 16-cycle limit.
module tb_draw_scheduler;
   localparam int NL = 6;
   localparam int XW = 9;
   localparam int YW = 8;
   localparam int NE = 2 * NL;
`ifdef DRAW_SCHED_TIMEOUT_EN
   localparam int TO     = 16;
   localparam bit HAS_TO = 1'b1;
`else
   localparam int TO     = 4096;
   localparam bit HAS_TO = 1'b0;
`endif
   localparam int HUNG = 100000;

   logic clock, resetn, draw_go;
   logic [NL-1:0] draw_done, erase_done, draw_colour, erase_colour;
   logic [NL*XW-1:0] draw_x, erase_x;
   logic [NL*YW-1:0] draw_y, erase_y;
   logic [NL-1:0] draw_enable, erase_enable;
   logic vga_enable, all_drawing_done, busy, sched_error;
   logic [XW-1:0] x_out;
   logic [YW-1:0] y_out;
   logic [2:0] colour_out;

   draw_scheduler #(.NUM_LINES(NL), .X_W(XW), .Y_W(YW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .resetn(resetn), .draw_go(draw_go),
      .draw_done(draw_done), .erase_done(erase_done),
      .draw_colour(draw_colour), .erase_colour(erase_colour),
      .draw_x(draw_x), .draw_y(draw_y), .erase_x(erase_x), .erase_y(erase_y),
      .draw_enable(draw_enable), .erase_enable(erase_enable),
      .vga_enable(vga_enable), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
      .all_drawing_done(all_drawing_done), .busy(busy), .sched_error(sched_error)
   );

   // clock / reset block
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout time=%0t limit=2000000", $time);
      $fatal(1, "bench time limit reached");
   end

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int lat[NE];
   int next_lat[NE];
   int run_cnt[NE];
   bit fix_d2 = 1'b0;

   // Frame timeline: engine k (erase 0..NL-1, then draw 0..NL-1) runs cycles s[k]..s[k]+d[k]-1.
   bit m_active  = 1'b0;
   bit m_pending = 1'b0;
   int m_t0, m_end;
   int s[NE];
   int d[NE];
   logic [NL-1:0] exp_ee = '0, exp_de = '0;
   logic exp_vga = 1'b0, exp_done = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
   logic [XW-1:0] exp_x = '0;
   logic [YW-1:0] exp_y = '0;
   logic [2:0] exp_c = '0;

   logic [35:0] obs, expv;
   assign obs  = {erase_enable, draw_enable, vga_enable, x_out, y_out, colour_out,
                  all_drawing_done, busy, sched_error};
   assign expv = {exp_ee, exp_de, exp_vga, exp_x, exp_y, exp_c, exp_done, exp_busy, exp_err};

   // Behavioural engines: done rises once an engine has been enabled for more than lat cycles.
   always @(posedge clock) begin : engines
      bit en;
      logic [XW-1:0] xv;
      logic [YW-1:0] yv;
      logic cv;
      #1;
      for (int k = 0; k < NE; k++) begin
         if (k < NL) en = erase_enable[k];
         else        en = draw_enable[k-NL];
         run_cnt[k] = en ? run_cnt[k] + 1 : 0;
         xv = XW'($urandom_range(0, 319));
         yv = YW'($urandom_range(0, 239));
         cv = 1'($urandom_range(0, 1));
         if (fix_d2 && k == NL + 2) begin
            xv = 9'h0A5;
            yv = 8'h3C;
            cv = 1'b1;
         end
         if (k < NL) begin
            erase_done[k] = en ? (run_cnt[k] > lat[k]) : 1'($urandom_range(0, 1));
            erase_colour[k] = cv;
            erase_x[k*XW +: XW] = xv;
            erase_y[k*YW +: YW] = yv;
         end else begin
            draw_done[k-NL] = en ? (run_cnt[k] > lat[k]) : 1'($urandom_range(0, 1));
            draw_colour[k-NL] = cv;
            draw_x[(k-NL)*XW +: XW] = xv;
            draw_y[(k-NL)*YW +: YW] = yv;
         end
      end
   end

   // Reference model: expectations for the cycle that follows each edge.
   always @(posedge clock) begin : model
      int t;
      bit busy_prev;
      cyc = cyc + 1;
      t = cyc;
      if (resetn) begin
         m_active = 1'b0; m_pending = 1'b0;
         exp_ee = '0; exp_de = '0; exp_vga = 1'b0; exp_x = '0; exp_y = '0; exp_c = '0;
         exp_done = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
      end else begin
         exp_vga = 1'b0;
         if (m_active) begin
            for (int k = 0; k < NE; k++) begin
               if (t - 1 >= s[k] && t - 1 < s[k] + d[k] && (t - s[k]) <= lat[k]) begin
                  exp_vga = 1'b1;
                  if (k < NL) begin
                     exp_x = erase_x[k*XW +: XW]; exp_y = erase_y[k*YW +: YW];
                     exp_c = {3{erase_colour[k]}};
                  end else begin
                     exp_x = draw_x[(k-NL)*XW +: XW]; exp_y = draw_y[(k-NL)*YW +: YW];
                     exp_c = {3{draw_colour[k-NL]}};
                  end
               end
            end
         end
         busy_prev = m_active && (t - 1 >= m_t0) && (t - 1 <= m_end);
         if (!busy_prev) begin
            if (draw_go || m_pending) begin
               m_pending = 1'b0;
               m_active  = 1'b1;
               m_t0      = t;
               for (int k = 0; k < NE; k++) begin
                  lat[k] = next_lat[k];
                  d[k]   = (HAS_TO && lat[k] + 1 > TO) ? TO : lat[k] + 1;
                  s[k]   = (k == 0) ? t : s[k-1] + d[k-1] + 1;
               end
               m_end = s[NE-1] + d[NE-1] + 1;
            end
         end else if (draw_go) begin
            m_pending = 1'b1;
         end
         exp_ee = '0; exp_de = '0; exp_done = 1'b0; exp_busy = 1'b0;
         if (m_active) begin
            for (int k = 0; k < NE; k++) begin
               if (t >= s[k] && t < s[k] + d[k]) begin
                  if (k < NL) exp_ee[k] = 1'b1;
                  else        exp_de[k-NL] = 1'b1;
               end
               if (HAS_TO && lat[k] + 1 > TO && t == s[k] + d[k]) exp_err = 1'b1;
            end
            exp_done = (t == m_end);
            exp_busy = (t >= m_t0) && (t <= m_end);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_lat(input int lo, input int hi);
      for (int k = 0; k < NE; k++) next_lat[k] = $urandom_range(lo, hi);
   endtask

   task automatic start_frame();
      draw_go = 1'b1;
      tick();
      draw_go = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      draw_go = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (obs !== 36'h0) begin
         n_err++; $display("FAIL reset_outputs got=%h exp=%h", obs, 36'h0);
      end
      resetn = 1'b0;
      tick();
      n_checks++;
      if (obs !== 36'h0) begin
         n_err++; $display("FAIL reset_idle got=%h exp=%h", obs, 36'h0);
      end
   endtask

   task automatic test_sequence();
      int pulses, pulse_rel, e0, busy_low;
      pulses = 0; pulse_rel = -1; e0 = 0; busy_low = 0;
      for (int k = 0; k < NE; k++) next_lat[k] = 3;
      start_frame();
      for (int r = 0; r < 70; r++) begin
         if (r > 0) tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL seq_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (all_drawing_done) begin pulses++; pulse_rel = r; end
         if (erase_enable[0]) e0++;
         if (r <= 60 && busy !== 1'b1) busy_low++;
      end
      n_checks += 4;
      if (pulses != 1) begin n_err++; $display("FAIL seq_pulses got=%0d exp=1", pulses); end
      if (pulse_rel != 60) begin n_err++; $display("FAIL seq_done_time got=%0d exp=60", pulse_rel); end
      if (e0 != 4) begin n_err++; $display("FAIL seq_enable_len got=%0d exp=4", e0); end
      if (busy_low != 0) begin n_err++; $display("FAIL seq_busy low_cycles=%0d exp=0", busy_low); end
   endtask

   task automatic test_pixel_mux();
      bit prev_live, prev_end;
      int n_live;
      prev_live = 0; prev_end = 0; n_live = 0;
      for (int k = 0; k < NE; k++) next_lat[k] = 3;
      fix_d2 = 1'b1;
      start_frame();
      for (int r = 0; r < 70; r++) begin
         if (r > 0) tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL pix_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (prev_live) begin
            n_live++;
            n_checks++;
            if ({vga_enable, x_out, y_out, colour_out} !== {1'b1, 9'h0A5, 8'h3C, 3'b111}) begin
               n_err++;
               $display("FAIL pix_value got vga=%b x=%h y=%h c=%b exp vga=1 x=0a5 y=3c c=111",
                        vga_enable, x_out, y_out, colour_out);
            end
         end
         if (prev_end) begin
            n_checks++;
            if (vga_enable !== 1'b0) begin n_err++; $display("FAIL pix_after_done got=%b exp=0", vga_enable); end
         end
         prev_live = draw_enable[2] && !draw_done[2];
         prev_end  = draw_enable[2] && draw_done[2];
      end
      fix_d2 = 1'b0;
      n_checks++;
      if (n_live != 3) begin n_err++; $display("FAIL pix_count got=%0d exp=3", n_live); end
   endtask

   task automatic test_pending();
      int g[3];
      int pulses, r1;
      pulses = 0; r1 = -10;
      set_lat(2, 4);
      for (int i = 0; i < 3; i++) g[i] = $urandom_range(1, 40);
      start_frame();
      for (int r = 0; r < 220; r++) begin
         if (r > 0) tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL pend_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (all_drawing_done) begin
            pulses++;
            if (pulses == 1) r1 = r;
         end
         if (r == r1 + 1) begin
            n_checks++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL pend_idle_gap got=%b exp=0", busy); end
         end
         if (r == r1 + 2) begin
            n_checks++;
            if (erase_enable !== 6'b000001) begin
               n_err++; $display("FAIL pend_restart got=%b exp=000001", erase_enable);
            end
         end
         draw_go = (r == g[0] || r == g[1] || r == g[2]);
      end
      draw_go = 1'b0;
      n_checks++;
      if (pulses != 2) begin n_err++; $display("FAIL pend_pulses got=%0d exp=2", pulses); end
   endtask

   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      set_lat(0, 3);
      draw_go = 1'b1;
      for (int r = 0; r < 290; r++) begin
         tick();
         if (r == 150) draw_go = 1'b0;
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL b2b_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (all_drawing_done && r < 150) pulses++;
      end
      n_checks++;
      if (pulses < 2) begin n_err++; $display("FAIL b2b_frames got=%0d exp>=2", pulses); end
   endtask

   task automatic test_reset_mid_frame();
      bit seen;
      seen = 0;
      for (int k = 0; k < NE; k++) next_lat[k] = 3;
      start_frame();
      for (int r = 0; r < 100 && !seen; r++) begin
         tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL rst_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         seen = draw_enable[3];
      end
      n_checks++;
      if (!seen) begin n_err++; $display("FAIL rst_wait_draw3 got=0 exp=1"); end
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      n_checks++;
      if ({erase_enable, draw_enable, busy} !== 13'h0) begin
         n_err++; $display("FAIL rst_drop got=%h exp=0", {erase_enable, draw_enable, busy});
      end
      tick();
      start_frame();
      n_checks++;
      if ({erase_enable, draw_enable, busy} !== {6'b000001, 6'b000000, 1'b1}) begin
         n_err++; $display("FAIL rst_restart got=%b_%b_%b exp=000001_000000_1", erase_enable, draw_enable, busy);
      end
      for (int r = 0; r < 70; r++) begin
         tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL rst_obs2 cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
      end
   endtask

   task automatic test_done_preasserted();
      int e4, pulses, vga4;
      bit prev_e4;
      e4 = 0; pulses = 0; vga4 = 0; prev_e4 = 0;
      for (int k = 0; k < NE; k++) next_lat[k] = 3;
      next_lat[4] = 0;
      start_frame();
      for (int r = 0; r < 70; r++) begin
         if (r > 0) tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL pre_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (prev_e4 && vga_enable) vga4++;
         prev_e4 = erase_enable[4];
         if (erase_enable[4]) e4++;
         if (all_drawing_done) pulses++;
      end
      n_checks += 3;
      if (e4 != 1) begin n_err++; $display("FAIL pre_enable_len got=%0d exp=1", e4); end
      if (vga4 != 0) begin n_err++; $display("FAIL pre_vga got=%0d exp=0", vga4); end
      if (pulses != 1) begin n_err++; $display("FAIL pre_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_hung_engine();
      int de1, pulses;
      de1 = 0; pulses = 0;
      for (int k = 0; k < NE; k++) next_lat[k] = 3;
      next_lat[NL+1] = HUNG;
      start_frame();
      for (int r = 0; r < 100; r++) begin
         if (r > 0) tick();
         n_checks++;
         if (obs !== expv) begin
            n_err++; if (n_err < 40) $display("FAIL hung_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
         end
         if (draw_enable[1]) de1++;
         if (all_drawing_done) pulses++;
      end
`ifdef DRAW_SCHED_TIMEOUT_EN
      n_checks += 3;
      if (de1 != 16) begin n_err++; $display("FAIL hung_enable_len got=%0d exp=16", de1); end
      if (sched_error !== 1'b1) begin n_err++; $display("FAIL hung_error got=%b exp=1", sched_error); end
      if (pulses != 1) begin n_err++; $display("FAIL hung_pulses got=%0d exp=1", pulses); end
`else
      n_checks += 3;
      if (draw_enable[1] !== 1'b1) begin n_err++; $display("FAIL hung_stall got=%b exp=1", draw_enable[1]); end
      if (sched_error !== 1'b0) begin n_err++; $display("FAIL hung_error got=%b exp=0", sched_error); end
      if (pulses != 0) begin n_err++; $display("FAIL hung_pulses got=%0d exp=0", pulses); end
`endif
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      n_checks++;
      if (obs !== expv) begin n_err++; $display("FAIL hung_reset got=%h exp=%h", obs, expv); end
      tick();
   endtask

   task automatic test_random();
      for (int round = 0; round < 4; round++) begin
         set_lat(0, 6);
         for (int r = 0; r < 150; r++) begin
            draw_go = ($urandom_range(0, 19) == 0);
            resetn  = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++;
            if (obs !== expv) begin
               n_err++; if (n_err < 40) $display("FAIL rand_obs cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
         end
      end
      draw_go = 1'b0;
      resetn  = 1'b0;
   endtask

   initial begin
      resetn = 1'b1;
      draw_go = 1'b0;
      draw_done = '0; erase_done = '0; draw_colour = '0; erase_colour = '0;
      draw_x = '0; draw_y = '0; erase_x = '0; erase_y = '0;
      for (int k = 0; k < NE; k++) begin
         lat[k] = 3; next_lat[k] = 3; run_cnt[k] = 0;
      end
      test_reset();
      test_sequence();
      test_pixel_mux();
      test_pending();
      test_back_to_back();
      test_reset_mid_frame();
      test_done_preasserted();
      test_hung_engine();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
